// File: rtl/radix4.sv
// rtl/radix4.sv - 32x32 signed multiplier using radix-4 modified Booth recoding, one step per clock
module radix4 (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] inputM,
   input  logic [31:0] inputQ,
   output logic [63:0] out,
   input  logic [4:0]  cnt_init,
   input  logic [4:0]  cnt_step
);

   logic [31:0] m;
   logic [33:0] acc;
   logic [31:0] q;
   logic        qm1;
   logic [4:0]  cnt;
   logic [4:0]  cnt_target;
   logic [4:0]  cnt_next;
   logic        done;

   logic [33:0] m_ext;
   logic [33:0] pp;
   logic [33:0] sum;

   // 34 bits hold +/-2M for any 32-bit M, including -2^31
   always_comb begin
      m_ext = {{2{m[31]}}, m};
      pp    = '0;
      case ({q[1:0], qm1})
         3'b001, 3'b010: pp = m_ext;
         3'b011:         pp = m_ext << 1;
         3'b100:         pp = -(m_ext << 1);
         3'b101, 3'b110: pp = -m_ext;
         default:        pp = '0;
      endcase
      sum      = acc + pp;
      cnt_next = cnt + cnt_step;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m          <= inputM;
         q          <= inputQ;
         qm1        <= 1'b0;
         acc        <= '0;
         cnt        <= cnt_init;
         cnt_target <= cnt_init + 5'd16;
         done       <= 1'b0;
         out        <= '0;
      end else if (!done) begin
         // {acc, q, qm1} shifts right arithmetically by two after the add
         acc <= {{2{sum[33]}}, sum[33:2]};
         q   <= {sum[1:0], q[31:2]};
         qm1 <= q[1];
         cnt <= cnt_next;
         if (cnt_next == cnt_target) begin
            done <= 1'b1;
            out  <= {sum[33:0], q[31:2]};
         end
      end
   end

endmodule

// File: tb/tb_radix4.sv
// tb/tb_radix4.sv - self-checking bench for radix4: vector table, random products, reset/latency corners
module tb_radix4;

   logic        clk;
   logic        reset;
   logic [31:0] inputM;
   logic [31:0] inputQ;
   logic [63:0] out;
   logic [4:0]  cnt_init;
   logic [4:0]  cnt_step;

   int tests;
   int fails;

   radix4 dut (
      .clk      (clk),
      .reset    (reset),
      .inputM   (inputM),
      .inputQ   (inputQ),
      .out      (out),
      .cnt_init (cnt_init),
      .cnt_step (cnt_step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] m;
      logic [31:0] q;
      logic [63:0] p;
   } vec_t;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reset for 'hold' edges with operands applied, then run 40 cycles and sample
   task automatic do_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [63:0] exp);
      @(negedge clk);
      inputM = a;
      inputQ = b;
      reset  = 1'b1;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      check({name, "_rst_out"}, out, 64'd0);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check(name, out, exp);
   endtask

   vec_t vecs[$];

   initial begin
      logic [63:0] held;
      logic [63:0] e;
      logic [31:0] a;
      logic [31:0] b;
      bit          bad;

      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      inputM   = '0;
      inputQ   = '0;
      cnt_init = 5'd0;
      cnt_step = 5'd1;

      vecs.push_back('{32'h00087234, 32'h00000348, 64'h000000001BB6BAA0});
      vecs.push_back('{32'h50647236, 32'h50612336, 64'h193DE4CED7437964});
      vecs.push_back('{32'hB887CAAF, 32'h887CAAF3, 64'h215D8B0A7A419A1D});
      vecs.push_back('{32'h00087234, 32'hFFFFFEFD, 64'hFFFFFFFFF7747564});
      vecs.push_back('{32'hFFFFFEFD, 32'h00087234, 64'hFFFFFFFFF7747564});
      vecs.push_back('{32'hB887CAAF, 32'h50647236, ref_mul(32'hB887CAAF, 32'h50647236)});
      vecs.push_back('{32'hFFFFFEFD, 32'hFFFFFEFD, 64'h0000000000010609});
      vecs.push_back('{32'h00000001, 32'h50647236, 64'h0000000050647236});
      vecs.push_back('{32'hB887CAAF, 32'h00000001, 64'hFFFFFFFFB887CAAF});
      vecs.push_back('{32'h00000000, 32'hB887CAAF, 64'h0});
      vecs.push_back('{32'h50647236, 32'h00000000, 64'h0});
      vecs.push_back('{32'h80000000, 32'h80000000, 64'h4000000000000000});
      vecs.push_back('{32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000});
      vecs.push_back('{32'hFFFFFFFF, 32'h80000000, 64'h0000000080000000});

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", out, 64'd0);

      foreach (vecs[i])
         do_mul($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, 3, vecs[i].p);

      for (int i = 0; i < 30; i++) begin
         a = $urandom;
         b = $urandom;
         do_mul($sformatf("rand%0d", i), a, b, 1 + (i % 3), ref_mul(a, b));
      end

      // out is 0 until the product appears, never a partial sum, and is ready by edge 17
      a = 32'hDEADBEEF;
      b = 32'h12345679;
      e = ref_mul(a, b);
      @(negedge clk);
      inputM = a;
      inputQ = b;
      reset  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bad   = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         if (out !== 64'd0 && out !== e) bad = 1'b1;
      end
      check("no_partial_on_out", {63'd0, bad}, 64'd0);
      check("latency_17", out, e);

      // result holds for 45 cycles after done
      held = out;
      bad  = 1'b0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (out !== held) bad = 1'b1;
      end
      check("hold_stable", {63'd0, bad}, 64'd0);

      // abort 5 cycles in, restart with new operands; later operand changes are ignored
      @(negedge clk);
      inputM = 32'h13579BDF;
      inputQ = 32'h2468ACE0;
      reset  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      inputM = 32'hCAFEF00D;
      inputQ = 32'h8BADF00D;
      reset  = 1'b1;
      @(negedge clk);
      check("midreset_out_zero", out, 64'd0);
      reset  = 1'b0;
      inputM = 32'h11111111;
      inputQ = 32'h22222222;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("midreset_new_product", out, ref_mul(32'hCAFEF00D, 32'h8BADF00D));

      // long reset with changing operands: last reset edge wins
      @(negedge clk);
      reset  = 1'b1;
      inputM = 32'h0000FFFF;
      inputQ = 32'h0000FFFF;
      @(negedge clk);
      inputM = 32'hFFFF0001;
      inputQ = 32'h00012345;
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      check("long_reset_last_ops", out, ref_mul(32'hFFFF0001, 32'h00012345));

      // counter wrapping past 31 still gives 16 steps
      cnt_init = 5'd20;
      do_mul("cnt_init20", 32'h7654321F, 32'h9ABCDEF1, 2, ref_mul(32'h7654321F, 32'h9ABCDEF1));
      cnt_init = 5'd0;

      // cnt_step 0 never completes
      cnt_step = 5'd0;
      do_mul("step0_stays0", 32'h50647236, 32'h50612336, 3, 64'd0);
      cnt_step = 5'd1;
      do_mul("after_step0", 32'h50647236, 32'h50612336, 3, 64'h193DE4CED7437964);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
